// File: rtl/enytank_pkg.sv
// Shared definitions for the enemy tank / enemy bullet logic:
// direction codes, grid defaults and the bullet state encoding.
package enytank_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int X_MAX_DEF      = 16;
  localparam int Y_MAX_DEF      = 20;
  localparam int STEP_TICKS_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FLY  = 2'd2,
    ST_END  = 2'd3
  } bul_state_e;

  function automatic logic pos_match(input logic [4:0] ax, input logic [4:0] ay,
                                     input logic [4:0] bx, input logic [4:0] by);
    return (ax == bx) && (ay == by);
  endfunction

endpackage

// File: rtl/enybul_app_step_divider.sv
// Step divider: counts enabled step_tick strobes and emits a one-cycle
// move strobe on every STEP_TICKS-th one. Synchronous clear restarts the count.
module step_divider
  import enytank_pkg::*;
#(
  parameter int STEP_TICKS = STEP_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic step_tick,
  output logic move_stb
);

  localparam logic [3:0] TERM = 4'(STEP_TICKS - 1);

  logic [3:0] cnt_q, cnt_d;

  // Tick counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  // Count enabled ticks; wrap to zero on the tick that completes a period.
  always_comb begin
    move_stb = en && step_tick && (cnt_q == TERM);
    cnt_d    = cnt_q;
    if (clr)                  cnt_d = 4'd0;
    else if (en && step_tick) cnt_d = move_stb ? 4'd0 : cnt_q + 4'd1;
  end

endmodule

// File: rtl/enybul_app.sv
// Enemy bullet engine. Accepts a fire request from a live enemy tank, latches
// its position and direction, steps one cell per move period and reports
// busy / player-hit back to the game logic.
//
// state | meaning
// IDLE  | no bullet; waiting for fire_req with tank_alive
// LOAD  | position latched; one cycle, checks point-blank hit
// FLY   | bullet moving; hit check has priority over the step
// END   | one cycle; pulses mytank_hit if entered via hit
module enybul_app
  import enytank_pkg::*;
#(
  parameter int X_MAX      = X_MAX_DEF,
  parameter int Y_MAX      = Y_MAX_DEF,
  parameter int STEP_TICKS = STEP_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_tick,
  input  logic       fire_req,
  input  logic       tank_alive,
  input  logic [4:0] tank_xpos,
  input  logic [4:0] tank_ypos,
  input  logic [1:0] tank_dir,
  input  logic [4:0] mytank_xpos,
  input  logic [4:0] mytank_ypos,
  output logic       bul_busy,
  output logic [4:0] bul_x,
  output logic [4:0] bul_y,
  output logic [1:0] bul_dir,
  output logic       mytank_hit
);

  bul_state_e state_q, state_d;
  logic [4:0] bul_x_q, bul_x_d;
  logic [4:0] bul_y_q, bul_y_d;
  logic [1:0] bul_dir_q, bul_dir_d;
  logic       hit_q, hit_d;
  logic       at_player;
  logic       move_stb;

  assign at_player = pos_match(bul_x_q, bul_y_q, mytank_xpos, mytank_ypos);

  // Ticks only count while flying and not hitting; any other state restarts the period.
  step_divider #(.STEP_TICKS(STEP_TICKS)) u_step_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q != ST_FLY),
    .en       ((state_q == ST_FLY) && !at_player),
    .step_tick(step_tick),
    .move_stb (move_stb)
  );

  // State and bullet registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bul_x_q   <= 5'd0;
      bul_y_q   <= 5'd0;
      bul_dir_q <= DIR_UP;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bul_x_q   <= bul_x_d;
      bul_y_q   <= bul_y_d;
      bul_dir_q <= bul_dir_d;
      hit_q     <= hit_d;
    end
  end

  // Next state and bullet position; edge checks use the pre-move position.
  always_comb begin
    state_d   = state_q;
    bul_x_d   = bul_x_q;
    bul_y_d   = bul_y_q;
    bul_dir_d = bul_dir_q;
    hit_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_req && tank_alive) begin
          state_d   = ST_LOAD;
          bul_x_d   = tank_xpos;
          bul_y_d   = tank_ypos;
          bul_dir_d = tank_dir;
        end
      end
      ST_LOAD: begin
        if (at_player) begin
          state_d = ST_END;
          hit_d   = 1'b1;
        end else begin
          state_d = ST_FLY;
        end
      end
      ST_FLY: begin
        if (at_player) begin
          state_d = ST_END;
          hit_d   = 1'b1;
        end else if (move_stb) begin
          case (bul_dir_q)
            DIR_UP:    if (bul_y_q == 5'd0)        state_d = ST_END; else bul_y_d = bul_y_q - 5'd1;
            DIR_DOWN:  if (bul_y_q == 5'(Y_MAX))   state_d = ST_END; else bul_y_d = bul_y_q + 5'd1;
            DIR_LEFT:  if (bul_x_q == 5'd0)        state_d = ST_END; else bul_x_d = bul_x_q - 5'd1;
            default:   if (bul_x_q == 5'(X_MAX))   state_d = ST_END; else bul_x_d = bul_x_q + 5'd1;
          endcase
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    bul_busy   = (state_q != ST_IDLE);
    mytank_hit = (state_q == ST_END) && hit_q;
    bul_x      = bul_x_q;
    bul_y      = bul_y_q;
    bul_dir    = bul_dir_q;
  end

endmodule

// File: tb/tb_enybul_app.sv
// Bench for enybul_app: two instances (STEP_TICKS 1 and 3) share stimulus and
// are compared every cycle against a flight-level reference model.
module tb_enybul_app;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_tick = 1'b0;
  logic       fire_req = 1'b0;
  logic       tank_alive = 1'b0;
  logic [4:0] tank_xpos = '0;
  logic [4:0] tank_ypos = '0;
  logic [1:0] tank_dir = '0;
  logic [4:0] mytank_xpos = '0;
  logic [4:0] mytank_ypos = '0;

  logic       busy_o [2];
  logic [4:0] x_o    [2];
  logic [4:0] y_o    [2];
  logic [1:0] dir_o  [2];
  logic       hit_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enybul_app #(.STEP_TICKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .step_tick(step_tick), .fire_req(fire_req),
    .tank_alive(tank_alive), .tank_xpos(tank_xpos), .tank_ypos(tank_ypos),
    .tank_dir(tank_dir), .mytank_xpos(mytank_xpos), .mytank_ypos(mytank_ypos),
    .bul_busy(busy_o[0]), .bul_x(x_o[0]), .bul_y(y_o[0]), .bul_dir(dir_o[0]),
    .mytank_hit(hit_o[0])
  );

  enybul_app #(.STEP_TICKS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .step_tick(step_tick), .fire_req(fire_req),
    .tank_alive(tank_alive), .tank_xpos(tank_xpos), .tank_ypos(tank_ypos),
    .tank_dir(tank_dir), .mytank_xpos(mytank_xpos), .mytank_ypos(mytank_ypos),
    .bul_busy(busy_o[1]), .bul_x(x_o[1]), .bul_y(y_o[1]), .bul_dir(dir_o[1]),
    .mytank_hit(hit_o[1])
  );

  // Reference model: one record per instance describing the bullet in flight.
  int steps [2] = '{1, 3};
  bit m_busy [2];
  bit m_last [2];
  bit m_hit  [2];
  int m_x    [2];
  int m_y    [2];
  int m_dir  [2];
  int m_age  [2];
  int m_ticks[2];
  int hit_cnt[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_last[k] = 0; m_hit[k] = 0;
      m_x[k] = 0; m_y[k] = 0; m_dir[k] = 0; m_age[k] = 0; m_ticks[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int nx, ny;
    if (!m_busy[k]) begin
      if (fire_req && tank_alive) begin
        m_busy[k] = 1; m_last[k] = 0; m_hit[k] = 0;
        m_x[k] = int'(tank_xpos); m_y[k] = int'(tank_ypos); m_dir[k] = int'(tank_dir);
        m_age[k] = 0; m_ticks[k] = 0;
      end
    end else if (m_last[k]) begin
      m_busy[k] = 0; m_last[k] = 0; m_hit[k] = 0;
    end else begin
      if (m_x[k] == int'(mytank_xpos) && m_y[k] == int'(mytank_ypos)) begin
        m_last[k] = 1; m_hit[k] = 1;
      end else if (m_age[k] > 0 && step_tick) begin
        m_ticks[k]++;
        if (m_ticks[k] == steps[k]) begin
          m_ticks[k] = 0;
          nx = m_x[k]; ny = m_y[k];
          case (m_dir[k])
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
          endcase
          if (nx < 0 || nx > 16 || ny < 0 || ny > 20) m_last[k] = 1;
          else begin m_x[k] = nx; m_y[k] = ny; end
        end
      end
      m_age[k]++;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d_busy", k), 32'(busy_o[k]), 32'(m_busy[k]));
      check($sformatf("dut%0d_hit", k), 32'(hit_o[k]), 32'(m_busy[k] && m_last[k] && m_hit[k]));
      if (m_busy[k]) begin
        check($sformatf("dut%0d_x", k), 32'(x_o[k]), 32'(m_x[k]));
        check($sformatf("dut%0d_y", k), 32'(y_o[k]), 32'(m_y[k]));
        check($sformatf("dut%0d_dir", k), 32'(dir_o[k]), 32'(m_dir[k]));
      end
      if (hit_o[k] === 1'b1) hit_cnt[k]++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
    @(negedge clk);
    compare_all();
  endtask

  task automatic shoot(input int tx, input int ty, input int td, input int mx, input int my);
    tank_xpos = 5'(tx); tank_ypos = 5'(ty); tank_dir = 2'(td);
    mytank_xpos = 5'(mx); mytank_ypos = 5'(my);
    tank_alive = 1'b1; fire_req = 1'b1;
    cycle();
    fire_req = 1'b0;
  endtask

  task automatic drain(input int n);
    step_tick = 1'b1;
    repeat (n) cycle();
    step_tick = 1'b0;
    cycle();
    check("drain_idle0", 32'(busy_o[0]), 32'd0);
    check("drain_idle1", 32'(busy_o[1]), 32'd0);
  endtask

  initial begin
    int h0, h1, guard;
    model_reset();
    hit_cnt = '{0, 0};
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 32'(busy_o[k]), 32'd0);
      check("rst_x", 32'(x_o[k]), 32'd0);
      check("rst_y", 32'(y_o[k]), 32'd0);
      check("rst_dir", 32'(dir_o[k]), 32'd0);
      check("rst_hit", 32'(hit_o[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // 1: fire right to the edge, no hit
    shoot(3, 5, 3, 16, 0);
    drain(80);

    // 2: fire up onto the player
    h0 = hit_cnt[0]; h1 = hit_cnt[1];
    shoot(8, 10, 0, 8, 6);
    drain(60);
    check("t2_hits0", 32'(hit_cnt[0] - h0), 32'd1);
    check("t2_hits1", 32'(hit_cnt[1] - h1), 32'd1);

    // 3: point-blank shot
    h0 = hit_cnt[0];
    shoot(2, 2, 1, 2, 2);
    check("t3_busy_load", 32'(busy_o[0]), 32'd1);
    drain(4);
    check("t3_hits0", 32'(hit_cnt[0] - h0), 32'd1);

    // 4: fire held through flight while the tank moves
    mytank_xpos = 5'd0; mytank_ypos = 5'd20;
    tank_alive = 1'b1; fire_req = 1'b1; step_tick = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tank_xpos = 5'($urandom_range(0, 16));
      tank_ypos = 5'($urandom_range(0, 19));
      tank_dir  = 2'($urandom_range(0, 3));
      cycle();
    end
    fire_req = 1'b0;
    drain(80);

    // 5: fire left from (5,0); ticks during LOAD ignored
    tank_xpos = 5'd5; tank_ypos = 5'd0; tank_dir = 2'd2;
    mytank_xpos = 5'd16; mytank_ypos = 5'd20;
    fire_req = 1'b1; step_tick = 1'b1;
    cycle();
    fire_req = 1'b0;
    cycle();
    for (int i = 0; i < 60; i++) begin
      step_tick = 1'($urandom_range(0, 1));
      cycle();
    end
    drain(40);

    // 6: async reset mid-flight at (10,4)
    shoot(6, 4, 3, 16, 20);
    step_tick = 1'b1;
    guard = 0;
    while (m_x[0] != 10 && guard < 20) begin cycle(); guard++; end
    check("t6_reach", 32'(m_x[0]), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check("t6_rst_busy", 32'(busy_o[k]), 32'd0);
      check("t6_rst_x", 32'(x_o[k]), 32'd0);
      check("t6_rst_y", 32'(y_o[k]), 32'd0);
      check("t6_rst_hit", 32'(hit_o[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step_tick = 1'b0;
    tank_alive = 1'b0; fire_req = 1'b1;
    repeat (5) cycle();
    check("t6_dead_idle", 32'(busy_o[0]), 32'd0);
    fire_req = 1'b0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      fire_req   = ($urandom_range(0, 9) < 3);
      tank_alive = ($urandom_range(0, 9) != 0);
      step_tick  = ($urandom_range(0, 2) == 0);
      tank_xpos  = 5'($urandom_range(0, 16));
      tank_ypos  = 5'($urandom_range(0, 20));
      tank_dir   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        mytank_xpos = ($urandom_range(0, 1) == 0) ? tank_xpos : 5'($urandom_range(0, 16));
        mytank_ypos = ($urandom_range(0, 1) == 0) ? tank_ypos : 5'($urandom_range(0, 20));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
